// File: rtl/step_dir_pkg.sv
// Shared types and constants for the step/direction trajectory generator.
package step_dir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Divider counter width; never narrower than one bit so STEP_DIV=1 still builds.
  function automatic int div_width(input int step_div);
    return (step_div > 1) ? $clog2(step_div) : 1;
  endfunction

  localparam int STEP_DIV_DEFAULT = 1;
  localparam int DIV_W_DEFAULT    = div_width(STEP_DIV_DEFAULT);

endpackage

// File: rtl/step_timer.sv
// Step-rate divider: registered tick right after start, then every STEP_DIV cycles while run holds.
module step_timer
  import step_dir_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam int              DIV_W  = div_width(STEP_DIV);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic             tick_r;

  // Down-counter that reloads on every emitted tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (start) begin
      div_r  <= RELOAD;
      tick_r <= 1'b1;
    end else if (run) begin
      if (div_r == {DIV_W{1'b0}}) begin
        div_r  <= RELOAD;
        tick_r <= 1'b1;
      end else begin
        div_r  <= div_r - {{(DIV_W-1){1'b0}}, 1'b1};
        tick_r <= 1'b0;
      end
    end else begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/step_dir_gen.sv
// Turns a target position into step/direction pulses for the up/down counter.
// Optional SHORTEST_PATH_EN picks the shorter way around the 2^WIDTH circle.
module step_dir_gen
  import step_dir_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             abort,
  output logic             enable,
  output logic             direction,
  output logic [WIDTH-1:0] pos_out,
  output logic             busy,
  output logic             done
);

  state_t           state_r;
  logic [WIDTH-1:0] pos_r;
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] pos_next_s;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;
  logic             dir_calc_s;
  logic             accept_s;
  logic             start_s;
  logic             arrive_s;
  logic             run_s;
  logic             tick_s;

`ifdef SHORTEST_PATH_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] d_up_s;
`endif

  // Direction choice, next mirror value and handshake/arrival decode.
  always_comb begin
`ifdef SHORTEST_PATH_EN
    d_up_s     = target - pos_r;
    dir_calc_s = (d_up_s <= HALF) ? UP : DOWN;
`else
    dir_calc_s = (target > pos_r) ? UP : DOWN;
`endif
    if (dir_r == UP) begin
      pos_next_s = pos_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pos_next_s = pos_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end
    accept_s = (state_r == IDLE) && target_valid && ready_r;
    start_s  = accept_s && (target != pos_r);
    // A step landing on the target ends the move on the same edge.
    arrive_s = tick_s && (pos_next_s == target_r);
    run_s    = (state_r == MOVE) && !abort && !arrive_s;
  end

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .run   (run_s),
    .tick  (tick_s)
  );

  // Control FSM and position mirror; the mirror follows every emitted step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      pos_r    <= {WIDTH{1'b0}};
      target_r <= {WIDTH{1'b0}};
      dir_r    <= UP;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      if (tick_s) begin
        pos_r <= pos_next_s;
      end
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            target_r <= target;
            ready_r  <= 1'b0;
            if (start_s) begin
              state_r <= MOVE;
              busy_r  <= 1'b1;
              dir_r   <= dir_calc_s;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        MOVE: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else if (arrive_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign target_ready = ready_r;
  assign enable       = tick_s;
  assign direction    = dir_r;
  assign pos_out      = pos_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_step_dir_gen.sv
// Directed bench for step_dir_gen: one instance with STEP_DIV=1, one with STEP_DIV=4.
module tb_step_dir_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] t1 = 8'd0, t4 = 8'd0;
  logic       v1 = 1'b0, v4 = 1'b0;
  logic       a1 = 1'b0, a4 = 1'b0;
  logic       r1, r4, e1, e4, d1, d4, b1, b4, dn1, dn4;
  logic [7:0] p1, p4;
  logic [7:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int w_en, w_first, w_last, w_done_at, w_ndone, w_busy, w_dir;

  always #5 clk = ~clk;

  step_dir_gen #(.WIDTH(8), .STEP_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .target(t1), .target_valid(v1), .target_ready(r1),
    .abort(a1), .enable(e1), .direction(d1), .pos_out(p1), .busy(b1), .done(dn1)
  );

  step_dir_gen #(.WIDTH(8), .STEP_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .target(t4), .target_valid(v4), .target_ready(r4),
    .abort(a4), .enable(e4), .direction(d4), .pos_out(p4), .busy(b4), .done(dn4)
  );

  // Stand-in for the downstream up/down counter fed by the STEP_DIV=1 instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt1 <= 8'd0;
    else if (e1) cnt1 <= d1 ? cnt1 + 8'd1 : cnt1 - 8'd1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a target for one cycle; returns at the negedge of capture+1.
  task automatic send(input bit sel4, input logic [7:0] t);
    if (sel4) begin t4 = t; v4 = 1'b1; end
    else begin t1 = t; v1 = 1'b1; end
    @(negedge clk);
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  // Sample ncyc cycles (k=1 is the cycle after capture) and summarise activity.
  task automatic watch(input bit sel4, input int ncyc);
    logic en, dr, dn, bs;
    w_en = 0; w_first = 0; w_last = 0; w_done_at = 0; w_ndone = 0; w_busy = 0; w_dir = 1;
    for (int k = 1; k <= ncyc; k++) begin
      en = sel4 ? e4 : e1;
      dr = sel4 ? d4 : d1;
      dn = sel4 ? dn4 : dn1;
      bs = sel4 ? b4 : b1;
      if (en) begin
        w_en++;
        if (w_first == 0) w_first = k;
        w_last = k;
        w_dir = int'(dr);
      end
      if (dn) begin w_ndone++; w_done_at = k; end
      if (bs) w_busy = 1;
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_pos1", p1, 0);
    check_eq("rst_en1", e1, 0);
    check_eq("rst_dir1", d1, 1);
    check_eq("rst_busy1", b1, 0);
    check_eq("rst_done1", dn1, 0);
    check_eq("rst_ready1", r1, 1);
    check_eq("rst_en4", e4, 0);
    check_eq("rst_ready4", r4, 1);

    // 0 -> 5 with continuous enable
    send(0, 8'd5);
    watch(0, 7);
    check_eq("t5_steps", w_en, 5);
    check_eq("t5_first", w_first, 1);
    check_eq("t5_last", w_last, 5);
    check_eq("t5_dir", w_dir, 1);
    check_eq("t5_done_at", w_done_at, 6);
    check_eq("t5_ndone", w_ndone, 1);
    check_eq("t5_pos", p1, 5);
    check_eq("t5_ready", r1, 1);
    check_eq("t5_counter", cnt1, 5);

    // STEP_DIV=4: 0 -> 10, then 10 -> 8
    send(1, 8'd10);
    watch(1, 40);
    check_eq("d4_up_steps", w_en, 10);
    check_eq("d4_up_last", w_last, 37);
    check_eq("d4_up_done_at", w_done_at, 38);
    check_eq("d4_up_pos", p4, 10);
    send(1, 8'd8);
    watch(1, 8);
    check_eq("d4_dn_steps", w_en, 2);
    check_eq("d4_dn_first", w_first, 1);
    check_eq("d4_dn_last", w_last, 5);
    check_eq("d4_dn_dir", w_dir, 0);
    check_eq("d4_dn_done_at", w_done_at, 6);
    check_eq("d4_dn_pos", p4, 8);

    // 5 -> 7, then a zero-length move to 7
    send(0, 8'd7);
    watch(0, 4);
    check_eq("p7_steps", w_en, 2);
    check_eq("p7_pos", p1, 7);
    send(0, 8'd7);
    watch(0, 3);
    check_eq("zero_steps", w_en, 0);
    check_eq("zero_busy", w_busy, 0);
    check_eq("zero_done_at", w_done_at, 1);
    check_eq("zero_ndone", w_ndone, 1);
    check_eq("zero_ready", r1, 1);

    // Async reset in the middle of 7 -> 100
    send(0, 8'd100);
    watch(0, 5);
    check_eq("mid_steps", w_en, 5);
    check_eq("mid_pos", p1, 12);
    check_eq("mid_counter", cnt1, 12);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_en", e1, 0);
    check_eq("arst_busy", b1, 0);
    check_eq("arst_pos", p1, 0);
    check_eq("arst_dir", d1, 1);
    check_eq("arst_ready", r1, 1);
    check_eq("arst_pos4", p4, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_counter", cnt1, 0);
    check_eq("post_rst_pos", p1, 0);
    check_eq("post_rst_en", e1, 0);

    // Abort after the third STEP_DIV=4 pulse of 0 -> 20
    send(1, 8'd20);
    watch(1, 9);
    check_eq("ab_steps", w_en, 3);
    a4 = 1'b1;
    @(negedge clk);
    a4 = 1'b0;
    watch(1, 6);
    check_eq("ab_no_steps", w_en, 0);
    check_eq("ab_no_done", w_ndone, 0);
    check_eq("ab_no_busy", w_busy, 0);
    check_eq("ab_pos", p4, 3);
    check_eq("ab_ready", r4, 1);
    send(1, 8'd3);
    watch(1, 3);
    check_eq("ab_t3_steps", w_en, 0);
    check_eq("ab_t3_done_at", w_done_at, 1);

    // 0 -> 250: long way up, or six steps down across the wrap
    send(0, 8'd250);
    watch(0, 260);
`ifdef SHORTEST_PATH_EN
    check_eq("t250_steps", w_en, 6);
    check_eq("t250_dir", w_dir, 0);
    check_eq("t250_done_at", w_done_at, 7);
`else
    check_eq("t250_steps", w_en, 250);
    check_eq("t250_dir", w_dir, 1);
    check_eq("t250_done_at", w_done_at, 251);
`endif
    check_eq("t250_pos", p1, 250);
    check_eq("t250_counter", cnt1, 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
